// File: rtl/icache_prefetch.sv
// Direct-mapped, one-word-per-frame instruction cache with an optional next-line prefetch.
// Demand misses stall the datapath while the frame is filled from the memory controller.
module icache_prefetch #(
  parameter int SETS     = 16,
  parameter int PREFETCH = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_PREFETCH = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_fill_addr;
  logic          r_flush_pend;
  logic [SETS-1:0] r_valid;
  logic [TW-1:0] r_tag  [SETS];
  logic [31:0]   r_data [SETS];
  logic [31:0]   r_hit_count;
  logic [31:0]   r_miss_count;

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [31:0]   w_pf_addr;
  logic [IW-1:0] w_pf_idx;
  logic [TW-1:0] w_pf_tag;
  logic [IW-1:0] w_fill_idx;
  logic [TW-1:0] w_fill_tag;
  logic          w_lookup;
  logic          w_pf_present;
  logic          w_unused;

  logic [1:0]    w_next;
  logic          w_ihit;
  logic          w_iren;
  logic [31:0]   w_iaddr;
  logic          w_miss;
  logic          w_clear;
  logic          w_wr_en;
  logic [IW-1:0] w_wr_idx;
  logic [TW-1:0] w_wr_tag;

  assign w_idx        = imemaddr[IW+1:2];
  assign w_tag        = imemaddr[31:IW+2];
  assign w_pf_addr    = r_fill_addr + 32'd4;
  assign w_pf_idx     = w_pf_addr[IW+1:2];
  assign w_pf_tag     = w_pf_addr[31:IW+2];
  assign w_fill_idx   = r_fill_addr[IW+1:2];
  assign w_fill_tag   = r_fill_addr[31:IW+2];
  assign w_lookup     = imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pf_present = r_valid[w_pf_idx] && (r_tag[w_pf_idx] == w_pf_tag);
  assign w_unused     = ^imemaddr[1:0];

  // Next-state, memory request and fill-write decode
  always_comb begin
    w_next   = r_state;
    w_ihit   = 1'b0;
    w_iren   = 1'b0;
    w_iaddr  = 32'd0;
    w_miss   = 1'b0;
    w_clear  = 1'b0;
    w_wr_en  = 1'b0;
    w_wr_idx = w_fill_idx;
    w_wr_tag = w_fill_tag;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_clear = 1'b1;
        end else if (w_lookup) begin
          w_ihit = 1'b1;
        end else if (imemREN) begin
          w_miss = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_FETCH: begin
        w_iren  = 1'b1;
        w_iaddr = r_fill_addr;
        if (!iwait) begin
          w_wr_en = 1'b1;
          if ((PREFETCH == 1) && !w_pf_present) begin
            w_next = S_PREFETCH;
          end else begin
            w_next  = S_IDLE;
            w_clear = r_flush_pend | flush;
          end
        end else begin
          w_next = S_FETCH;
        end
      end
      S_PREFETCH: begin
        w_iren   = 1'b1;
        w_iaddr  = w_pf_addr;
        w_wr_idx = w_pf_idx;
        w_wr_tag = w_pf_tag;
        // The frame being prefetched cannot serve a hit until its fill lands
        w_ihit   = w_lookup && (w_idx != w_pf_idx);
        if (!iwait) begin
          w_wr_en = 1'b1;
          w_next  = S_IDLE;
          w_clear = r_flush_pend | flush;
        end else begin
          w_next = S_PREFETCH;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Control state, pending flush, valid bits and counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_fill_addr  <= 32'd0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_fill_addr  <= {imemaddr[31:2], 2'b00};
        r_miss_count <= r_miss_count + 32'd1;
      end
      if (w_ihit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_clear) begin
        r_flush_pend <= 1'b0;
      end else if (flush && (r_state != S_IDLE)) begin
        r_flush_pend <= 1'b1;
      end
      // A flush landing on the fill edge wins, so the just-filled frame ends invalid
      if (w_clear) begin
        r_valid <= '0;
      end else if (w_wr_en) begin
        r_valid[w_wr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= iload;
    end
  end

  assign ihit       = w_ihit;
  assign imemload   = w_ihit ? r_data[w_idx] : 32'd0;
  assign iREN       = w_iren;
  assign iaddr      = w_iaddr;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_prefetch.sv
// Directed bench for icache_prefetch: a scripted memory controller, a tag/valid model
// deciding when prefetches occur, and queues of expected fill addresses and load words.
module tb_icache_prefetch;

  logic        CLK;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] addr_q [$];
  logic [31:0] data_q [$];

  icache_prefetch #(.SETS(16), .PREFETCH(1)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    n_fail++;
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C22_0004;
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  function automatic logic [31:0] pop_addr();
    if (addr_q.size() == 0) return 32'hDEAD_BEEF;
    return addr_q.pop_front();
  endfunction

  function automatic logic [31:0] pop_data();
    if (data_q.size() == 0) return 32'hDEAD_BEEF;
    return data_q.pop_front();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counts();
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // One memory transaction: lat busy cycles then a ready cycle
  task automatic serve(input int lat, input bit hit_first, input bit flush_first);
    logic [31:0] a;
    a = pop_addr();
    for (int c = 0; c <= lat; c++) begin
      iwait = (c < lat) ? 1'b1 : 1'b0;
      iload = (c < lat) ? 32'h0 : mem(a);
      flush = (c == 0) ? flush_first : 1'b0;
      #3;
      check("iren_hold", iREN, 32'd1);
      check("iaddr", iaddr, a);
      if ((c == 0) && hit_first) begin
        check("ihit_retry", ihit, 32'd1);
        check("imemload_retry", imemload, pop_data());
        exp_hits++;
      end else begin
        check("ihit_busy", ihit, 32'd0);
      end
      tick();
      if (hit_first) imemREN = 1'b0;
    end
    iwait = 1'b1;
    iload = 32'h0;
    flush = 1'b0;
    m_valid[a[5:2]] = 1'b1;
    m_tag[a[5:2]]   = a[31:6];
  endtask

  task automatic miss_seq(input logic [31:0] addr, input int lf, input int lp);
    logic [31:0] pfa;
    bit          pf;
    pfa = addr + 32'd4;
    pf  = !(m_valid[pfa[5:2]] && (m_tag[pfa[5:2]] == pfa[31:6]));
    imemREN  = 1'b1;
    imemaddr = addr;
    #3;
    check("miss_ihit", ihit, 32'd0);
    check("miss_imemload", imemload, 32'd0);
    check("miss_iren", iREN, 32'd0);
    addr_q.push_back(addr);
    data_q.push_back(mem(addr));
    exp_misses++;
    tick();
    serve(lf, 1'b0, 1'b0);
    if (pf) begin
      addr_q.push_back(pfa);
      serve(lp, 1'b1, 1'b0);
    end else begin
      #3;
      check("hit_after_fill", ihit, 32'd1);
      check("imemload_after_fill", imemload, pop_data());
      exp_hits++;
      tick();
      imemREN = 1'b0;
    end
    #3;
    check("iren_idle", iREN, 32'd0);
    check("iaddr_idle", iaddr, 32'd0);
    check_counts();
    tick();
  endtask

  task automatic idle_hit(input logic [31:0] addr);
    imemREN  = 1'b1;
    imemaddr = addr;
    data_q.push_back(mem(addr));
    #3;
    check("idle_hit", ihit, 32'd1);
    check("idle_imemload", imemload, pop_data());
    exp_hits++;
    tick();
    imemREN = 1'b0;
    #3;
    check_counts();
    tick();
  endtask

  initial begin
    logic [31:0] a;
    bit          pf;
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0;
    iwait = 1'b1; iload = 32'h0;
    exp_hits = 32'd0; exp_misses = 32'd0;
    model_clear();
    for (int i = 0; i < 16; i++) m_tag[i] = 26'd0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_iren", iREN, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_ihit", ihit, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    check_counts();
    RST = 1'b0;
    tick();

    // Cold miss on 0x40 with 3 busy cycles, prefetch of 0x44, then hit on the prefetched word
    miss_seq(32'h0000_0040, 3, 2);
    idle_hit(32'h0000_0044);

    // Next line already resident: no prefetch, demand hit in IDLE
    miss_seq(32'h0000_003C, 1, 1);

    // Conflicts on index 0
    miss_seq(32'h0000_0000, 1, 1);
    miss_seq(32'h0000_0040, 2, 1);
    miss_seq(32'h0000_0000, 1, 1);

    // Flush pulsed while the fetch is waiting
    pf = !(m_valid[1] && (m_tag[1] == 26'd2));
    imemREN = 1'b1; imemaddr = 32'h0000_0080;
    #3;
    check("flush_first_ihit", ihit, 32'd0);
    addr_q.push_back(32'h0000_0080);
    exp_misses++;
    tick();
    imemREN = 1'b0;
    serve(2, 1'b0, 1'b1);
    if (pf) begin
      addr_q.push_back(32'h0000_0084);
      serve(1, 1'b0, 1'b0);
    end
    #3;
    check("flush_iren_drop", iREN, 32'd0);
    check_counts();
    tick();
    model_clear();
    miss_seq(32'h0000_0080, 1, 1);

    // Wrap-around prefetch to 0x0, then frame 0 hits
    miss_seq(32'hFFFF_FFFC, 1, 1);
    idle_hit(32'h0000_0000);

    // Hits while the prefetch of 0xC is outstanding
    imemREN = 1'b1; imemaddr = 32'h0000_0008;
    #3;
    check("pfx_miss_ihit", ihit, 32'd0);
    addr_q.push_back(32'h0000_0008);
    data_q.push_back(mem(32'h0000_0008));
    exp_misses++;
    tick();
    serve(1, 1'b0, 1'b0);
    addr_q.push_back(32'h0000_000C);
    a = pop_addr();
    iwait = 1'b1;
    #3;
    check("pf_iaddr", iaddr, a);
    check("pf_retry_hit", ihit, 32'd1);
    check("pf_retry_load", imemload, pop_data());
    exp_hits++;
    tick();
    imemaddr = 32'h0000_0000;
    data_q.push_back(mem(32'h0000_0000));
    #3;
    check("pf_other_hit", ihit, 32'd1);
    check("pf_other_load", imemload, pop_data());
    exp_hits++;
    tick();
    imemaddr = 32'h0000_000C;
    #3;
    check("pf_same_idx_stall", ihit, 32'd0);
    check("pf_same_idx_iren", iREN, 32'd1);
    tick();
    iwait = 1'b0; iload = mem(a);
    #3;
    check("pf_same_idx_fill", ihit, 32'd0);
    tick();
    iwait = 1'b1; iload = 32'h0;
    m_valid[3] = 1'b1; m_tag[3] = 26'd0;
    data_q.push_back(mem(32'h0000_000C));
    #3;
    check("pf_done_hit", ihit, 32'd1);
    check("pf_done_load", imemload, pop_data());
    exp_hits++;
    tick();
    imemREN = 1'b0;
    #3;
    check_counts();
    tick();

    // Flush in IDLE suppresses a would-be hit on frame 0
    imemREN = 1'b1; imemaddr = 32'h0000_0000; flush = 1'b1;
    #3;
    check("idle_flush_ihit", ihit, 32'd0);
    tick();
    flush = 1'b0; imemREN = 1'b0;
    model_clear();
    tick();

    // Reset in the middle of a fetch
    imemREN = 1'b1; imemaddr = 32'h0000_0000;
    #3;
    check("flushed_miss", ihit, 32'd0);
    tick();
    iwait = 1'b1;
    #3;
    check("rst_pre_iren", iREN, 32'd1);
    #1;
    RST = 1'b1;
    #1;
    check("rst_mid_iren", iREN, 32'd0);
    check("rst_mid_iaddr", iaddr, 32'd0);
    check("rst_mid_ihit", ihit, 32'd0);
    check("rst_mid_hits", hit_count, 32'd0);
    check("rst_mid_misses", miss_count, 32'd0);
    imemREN = 1'b0; iwait = 1'b0; iload = mem(32'h0000_0000);
    tick();
    tick();
    RST = 1'b0; iwait = 1'b1; iload = 32'h0;
    exp_hits = 32'd0; exp_misses = 32'd0;
    model_clear();
    addr_q.delete();
    data_q.delete();
    tick();
    miss_seq(32'h0000_0000, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
